// File: rtl/seg7_time_mux.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | seg7_time_mux : BCD time-of-day counter with load handshake and a scanned   |
// |                 seven-segment display. SEG7_TIME_BLANK_EN: blank MSD zero.  |
// | Revision      : 1.0                                                         |
// +-----------------------------------------------------------------------------+
module seg7_time_mux #(
   parameter int CLK_HZ   = 12500,
   parameter int DIGITS   = 6,
   parameter int SCAN_DIV = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  load_valid_i,
   output logic                  load_ready_o,
   input  logic [4*DIGITS-1:0]   load_time_i,
   output logic [4*DIGITS-1:0]   time_o,
   output logic                  sec_pulse_o,
   output logic                  err_o,
   output logic [6:0]            seg_o,
   output logic                  dp_o,
   output logic [DIGITS-1:0]     digit_sel_o
);

   localparam int C_PRESC_W = $clog2(CLK_HZ);
   localparam int C_SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int C_IDX_W   = $clog2(DIGITS);
   localparam int C_FIELDS  = DIGITS / 2;
   localparam int C_TW      = 4 * DIGITS;

   generate
      if (!(DIGITS == 2 || DIGITS == 4 || DIGITS == 6)) begin : g_bad_digits
         $error("seg7_time_mux: DIGITS must be 2, 4 or 6");
      end
      if (CLK_HZ < 4) begin : g_bad_clk_hz
         $error("seg7_time_mux: CLK_HZ must be at least 4");
      end
      if (SCAN_DIV < 1) begin : g_bad_scan_div
         $error("seg7_time_mux: SCAN_DIV must be at least 1");
      end
   endgenerate

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // Field 2 is hours (limit 23); lower fields are seconds/minutes (limit 59).
   function automatic logic [C_TW-1:0] bcd_inc(input logic [C_TW-1:0] t);
      logic [C_TW-1:0] r;
      logic            carry;
      logic [7:0]      f;
      logic [7:0]      lim;
      r     = t;
      carry = 1'b1;
      for (int i = 0; i < C_FIELDS; i++) begin
         f   = t[8*i +: 8];
         lim = (i == 2) ? 8'h23 : 8'h59;
         if (carry) begin
            if (f == lim) begin
               r[8*i +: 8] = 8'h00;
            end else begin
               carry = 1'b0;
               if (f[3:0] == 4'd9) r[8*i +: 8] = {f[7:4] + 4'd1, 4'd0};
               else                r[8*i +: 8] = {f[7:4], f[3:0] + 4'd1};
            end
         end
      end
      return r;
   endfunction

   // Nibbles are checked first, so a plain compare of the BCD byte is exact.
   function automatic logic time_ok(input logic [C_TW-1:0] t);
      logic       ok;
      logic [7:0] f;
      logic [7:0] lim;
      ok = 1'b1;
      for (int i = 0; i < C_FIELDS; i++) begin
         f   = t[8*i +: 8];
         lim = (i == 2) ? 8'h23 : 8'h59;
         if (f[3:0] > 4'd9 || f[7:4] > 4'd9 || f > lim) ok = 1'b0;
      end
      return ok;
   endfunction

   logic [C_TW-1:0]      time_q, time_d;
   logic [C_PRESC_W-1:0] presc_q, presc_d;
   logic [C_SCAN_W-1:0]  scan_q, scan_d;
   logic [C_IDX_W-1:0]   idx_q, idx_d;
   logic                 ready_q, ready_d;
   logic                 pulse_q, pulse_d;
   logic                 err_q, err_d;
   logic [6:0]           seg_q, seg_d;
   logic                 dp_q, dp_d;
   logic [DIGITS-1:0]    sel_q, sel_d;
   logic                 load_fire;
   logic                 tc;
   logic [3:0]           nib;

   always_comb begin
      load_fire = load_valid_i && ready_q;
      tc        = (presc_q == C_PRESC_W'(CLK_HZ - 1));
      time_d    = time_q;
      presc_d   = tc ? '0 : presc_q + C_PRESC_W'(1);
      pulse_d   = 1'b0;
      err_d     = 1'b0;
      ready_d   = !load_fire;

      // A valid load overrides a coincident tick; a rejected one does not.
      if (load_fire && time_ok(load_time_i)) begin
         time_d  = load_time_i;
         presc_d = '0;
      end else begin
         if (tc) begin
            time_d  = bcd_inc(time_q);
            pulse_d = 1'b1;
         end
         if (load_fire) err_d = 1'b1;
      end

      scan_d = scan_q + C_SCAN_W'(1);
      idx_d  = idx_q;
      if (scan_q == C_SCAN_W'(SCAN_DIV - 1)) begin
         scan_d = '0;
         idx_d  = (idx_q == C_IDX_W'(DIGITS - 1)) ? '0 : idx_q + C_IDX_W'(1);
      end

      nib = 4'd0;
      for (int d = 0; d < DIGITS; d++) begin
         if (idx_q == C_IDX_W'(d)) nib = time_q[4*d +: 4];
      end
`ifdef SEG7_TIME_BLANK_EN
      seg_d = (idx_q == C_IDX_W'(DIGITS - 1) && nib == 4'd0) ? 7'h00 : seg_decode(nib);
`else
      seg_d = seg_decode(nib);
`endif
      sel_d = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
      dp_d  = ((DIGITS > 2 && idx_q == C_IDX_W'(2)) || (DIGITS > 4 && idx_q == C_IDX_W'(4)))
              && (presc_q < C_PRESC_W'(CLK_HZ / 2));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         time_q  <= '0;
         presc_q <= '0;
         scan_q  <= '0;
         idx_q   <= '0;
         ready_q <= 1'b0;
         pulse_q <= 1'b0;
         err_q   <= 1'b0;
         seg_q   <= '0;
         dp_q    <= 1'b0;
         sel_q   <= '0;
      end else begin
         time_q  <= time_d;
         presc_q <= presc_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         ready_q <= ready_d;
         pulse_q <= pulse_d;
         err_q   <= err_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         sel_q   <= sel_d;
      end
   end

   assign time_o       = time_q;
   assign load_ready_o = ready_q;
   assign sec_pulse_o  = pulse_q;
   assign err_o        = err_q;
   assign seg_o        = seg_q;
   assign dp_o         = dp_q;
   assign digit_sel_o  = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_time_mux.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_seg7_time_mux : directed vector bench for seg7_time_mux (10 Hz, 6 dig)   |
// | Revision         : 1.0                                                      |
// +-----------------------------------------------------------------------------+
module tb_seg7_time_mux;

   typedef struct packed {
      logic [23:0] base;
      logic [23:0] ld;
      logic        err;
      logic [23:0] t;
   } ld_vec_t;

   typedef struct packed {
      logic [5:0] sel;
      logic [6:0] seg;
      logic       dp;
   } scan_vec_t;

`ifdef SEG7_TIME_BLANK_EN
   localparam logic [6:0] C_MSD_ZERO = 7'h00;
`else
   localparam logic [6:0] C_MSD_ZERO = 7'h3F;
`endif

   logic        clk;
   logic        rst_n;
   logic        load_valid;
   logic        load_ready;
   logic [23:0] load_time;
   logic [23:0] time_w;
   logic        sec_pulse;
   logic        err;
   logic [6:0]  seg;
   logic        dp;
   logic [5:0]  sel;

   int total = 0;
   int bad   = 0;

   ld_vec_t   ltab[10];
   scan_vec_t stab[24];

   seg7_time_mux #(.CLK_HZ(10), .DIGITS(6), .SCAN_DIV(2)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .load_valid_i (load_valid),
      .load_ready_o (load_ready),
      .load_time_i  (load_time),
      .time_o       (time_w),
      .sec_pulse_o  (sec_pulse),
      .err_o        (err),
      .seg_o        (seg),
      .dp_o         (dp),
      .digit_sel_o  (sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " time"},  32'(time_w),     32'h0);
      check({tag, " seg"},   32'(seg),        32'h0);
      check({tag, " sel"},   32'(sel),        32'h0);
      check({tag, " dp"},    32'(dp),         32'h0);
      check({tag, " pulse"}, 32'(sec_pulse),  32'h0);
      check({tag, " err"},   32'(err),        32'h0);
      check({tag, " ready"}, 32'(load_ready), 32'h0);
   endtask

   initial begin
      int         found;
      int         pc;
      logic [5:0] prev;

      rst_n      = 1'b0;
      load_valid = 1'b0;
      load_time  = '0;

      ltab[0] = '{24'h000000, 24'h235958, 1'b0, 24'h235958};
      ltab[1] = '{24'h123456, 24'h246000, 1'b1, 24'h123456};
      ltab[2] = '{24'h123456, 24'h125A00, 1'b1, 24'h123456};
      ltab[3] = '{24'h000000, 24'h996000, 1'b1, 24'h000000};
      ltab[4] = '{24'h000000, 24'h235959, 1'b0, 24'h235959};
      ltab[5] = '{24'h111111, 24'h006000, 1'b1, 24'h111111};
      ltab[6] = '{24'h111111, 24'h000060, 1'b1, 24'h111111};
      ltab[7] = '{24'h000000, 24'h195959, 1'b0, 24'h195959};
      ltab[8] = '{24'h195959, 24'h240000, 1'b1, 24'h195959};
      ltab[9] = '{24'h101010, 24'h00000A, 1'b1, 24'h101010};

      // Digit i shows '123456' digit i; seconds tick to ...57 at j=10, ...58 at j=20.
      stab[0]  = '{6'h01, 7'h7D, 1'b0};  stab[1]  = '{6'h01, 7'h7D, 1'b0};
      stab[2]  = '{6'h02, 7'h6D, 1'b0};  stab[3]  = '{6'h02, 7'h6D, 1'b0};
      stab[4]  = '{6'h04, 7'h66, 1'b1};  stab[5]  = '{6'h04, 7'h66, 1'b0};
      stab[6]  = '{6'h08, 7'h4F, 1'b0};  stab[7]  = '{6'h08, 7'h4F, 1'b0};
      stab[8]  = '{6'h10, 7'h5B, 1'b0};  stab[9]  = '{6'h10, 7'h5B, 1'b0};
      stab[10] = '{6'h20, 7'h06, 1'b0};  stab[11] = '{6'h20, 7'h06, 1'b0};
      stab[12] = '{6'h01, 7'h07, 1'b0};  stab[13] = '{6'h01, 7'h07, 1'b0};
      stab[14] = '{6'h02, 7'h6D, 1'b0};  stab[15] = '{6'h02, 7'h6D, 1'b0};
      stab[16] = '{6'h04, 7'h66, 1'b0};  stab[17] = '{6'h04, 7'h66, 1'b0};
      stab[18] = '{6'h08, 7'h4F, 1'b0};  stab[19] = '{6'h08, 7'h4F, 1'b0};
      stab[20] = '{6'h10, 7'h5B, 1'b1};  stab[21] = '{6'h10, 7'h5B, 1'b1};
      stab[22] = '{6'h20, 7'h06, 1'b0};  stab[23] = '{6'h20, 7'h06, 1'b0};

      // Reset held across edges, then release between edges.
      step(3);
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step(1);
      check("release ready", 32'(load_ready), 32'h1);
      check("release sel",   32'(sel),        32'h01);
      check("release seg",   32'(seg),        32'h3F);
      check("release time",  32'(time_w),     32'h0);
      step(8);
      check("edge9 pulse", 32'(sec_pulse), 32'h0);
      step(1);
      check("edge10 pulse", 32'(sec_pulse), 32'h1);
      check("edge10 time",  32'(time_w),    32'h000001);

      // Each record: valid base load, idle edge, then the load under test.
      for (int i = 0; i < 10; i++) begin
         load_valid = 1'b1;
         load_time  = ltab[i].base;
         step(1);
         check($sformatf("ld%0d base time", i), 32'(time_w),     32'(ltab[i].base));
         check($sformatf("ld%0d ready low", i), 32'(load_ready), 32'h0);
         load_valid = 1'b0;
         step(1);
         check($sformatf("ld%0d ready back", i), 32'(load_ready), 32'h1);
         load_valid = 1'b1;
         load_time  = ltab[i].ld;
         step(1);
         check($sformatf("ld%0d err", i),  32'(err),    32'(ltab[i].err));
         check($sformatf("ld%0d time", i), 32'(time_w), 32'(ltab[i].t));
         load_valid = 1'b0;
         step(1);
         check($sformatf("ld%0d err clear", i), 32'(err), 32'h0);
      end

      // Wrap through 23:59:59.
      load_valid = 1'b1;
      load_time  = 24'h235958;
      step(1);
      load_valid = 1'b0;
      check("wrap load time",  32'(time_w),     32'h235958);
      check("wrap ready low",  32'(load_ready), 32'h0);
      pc = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         if (sec_pulse) pc++;
         if (i == 1)  check("wrap ready back", 32'(load_ready), 32'h1);
         if (i == 9)  check("wrap t9 time",    32'(time_w),     32'h235958);
         if (i == 10) check("wrap t10 time",   32'(time_w),     32'h235959);
         if (i == 20) check("wrap t20 time",   32'(time_w),     32'h000000);
         if (i == 20) check("wrap t20 pulse",  32'(sec_pulse),  32'h1);
      end
      check("wrap pulse count", 32'(pc), 32'd2);

      // Prescaler just wrapped: the terminal-count edge is 10 edges away.
      step(9);
      load_valid = 1'b1;
      load_time  = 24'h120000;
      step(1);
      load_valid = 1'b0;
      check("coll valid time",  32'(time_w),    32'h120000);
      check("coll valid pulse", 32'(sec_pulse), 32'h0);
      check("coll valid err",   32'(err),       32'h0);
      step(9);
      check("coll next9 pulse", 32'(sec_pulse), 32'h0);
      step(1);
      check("coll next10 pulse", 32'(sec_pulse), 32'h1);
      check("coll next10 time",  32'(time_w),    32'h120001);
      step(9);
      load_valid = 1'b1;
      load_time  = 24'h996000;
      step(1);
      load_valid = 1'b0;
      check("coll bad pulse", 32'(sec_pulse), 32'h1);
      check("coll bad err",   32'(err),       32'h1);
      check("coll bad time",  32'(time_w),    32'h120002);

      // Align to the first cycle of digit 0, then load so the window is known.
      found = 0;
      prev  = sel;
      for (int k = 0; k < 30 && found == 0; k++) begin
         step(1);
         if (sel == 6'h01 && prev == 6'h20) found = 1;
         prev = sel;
      end
      check("scan sync", 32'(found), 32'd1);
      step(10);
      load_valid = 1'b1;
      load_time  = 24'h123456;
      step(1);
      load_valid = 1'b0;
      for (int j = 0; j < 24; j++) begin
         step(1);
         check($sformatf("scan%0d sel", j), 32'(sel), 32'(stab[j].sel));
         check($sformatf("scan%0d seg", j), 32'(seg), 32'(stab[j].seg));
         check($sformatf("scan%0d dp", j),  32'(dp),  32'(stab[j].dp));
      end

      // Most significant digit zero: dark when blanking is built in.
      load_valid = 1'b1;
      load_time  = 24'h091500;
      step(1);
      load_valid = 1'b0;
      found = 0;
      for (int k = 0; k < 14 && found == 0; k++) begin
         step(1);
         if (sel == 6'h20) found = 1;
      end
      check("msd sync", 32'(found), 32'd1);
      check("msd seg",  32'(seg),   32'(C_MSD_ZERO));

      // Asynchronous reset in the middle of a cycle with a load pending.
      load_valid = 1'b1;
      load_time  = 24'h123456;
      step(1);
      load_valid = 1'b0;
      check("mid pre time", 32'(time_w), 32'h123456);
      step(1);
      load_valid = 1'b1;
      load_time  = 24'h235958;
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("mid reset");
      load_valid = 1'b0;
      step(2);
      @(negedge clk);
      rst_n = 1'b1;
      step(1);
      check("mid rel ready", 32'(load_ready), 32'h1);
      check("mid rel time",  32'(time_w),     32'h0);
      check("mid rel sel",   32'(sel),        32'h01);
      step(8);
      check("mid edge9 pulse", 32'(sec_pulse), 32'h0);
      step(1);
      check("mid edge10 pulse", 32'(sec_pulse), 32'h1);
      check("mid edge10 time",  32'(time_w),    32'h000001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
